// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//   Pipeline control for the 5-stage CPU (IF/ID/EX/MEM/WB). Produces the
//   enable (as ~stall) and clear (flush) controls of the inter-stage
//   registers plus the EX-stage forwarding mux selects.
//
//   Hazards handled:
//     - data forwarding from MEM (ALU result) and WB (result)
//     - load-use stall when a load in EX feeds an instruction in ID
//     - multi-cycle EX operations (MC FSM + down-counter)
//     - data-memory wait states (req/ack handshake, MEM FSM)
//
//   Handshake: mem_req_m is held high by the MEM instruction until
//   mem_ack_m is seen high on a clock edge; the access completes in the
//   cycle where both are high, so an ack in the same cycle as the request
//   costs no stall.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   rs1_d, rs2_d               source registers of the instruction in ID
//   rs1_e, rs2_e, rd_e         source/destination registers in EX
//   rd_m, rd_w                 destination registers in MEM / WB
//   regwrite_m, regwrite_w     MEM / WB instruction writes its rd
//   memtoreg_e                 EX instruction is a load
//   mc_start_e                 EX instruction is a multi-cycle op
//   pc_src_e                   taken branch/jump resolved in EX
//   mem_req_m, mem_ack_m       data memory request / completion
//   fwd_a_e, fwd_b_e           00 regfile, 01 WB result, 10 MEM ALU result
//   stall_f/d/e/m              hold PC / IF-ID / ID-EX / EX-MEM
//   flush_d/e/m/w              bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
//   mc_busy                    multi-cycle FSM is in MC_BUSY
//   stall_cycles               free-running count of cycles with stall_f=1
//   mc_state_o, mem_state_o    debug: current MC / MEM FSM state
//   mc_cnt_o                   debug: multi-cycle down-counter
// ----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_BITS   = 4,
  parameter int MC_LATENCY = 4,
  parameter int ZERO_REG   = 1,
  localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs1_d,
  input  logic [REG_BITS-1:0] rs2_d,
  input  logic [REG_BITS-1:0] rs1_e,
  input  logic [REG_BITS-1:0] rs2_e,
  input  logic [REG_BITS-1:0] rd_e,
  input  logic [REG_BITS-1:0] rd_m,
  input  logic [REG_BITS-1:0] rd_w,
  input  logic                regwrite_m,
  input  logic                regwrite_w,
  input  logic                memtoreg_e,
  input  logic                mc_start_e,
  input  logic                pc_src_e,
  input  logic                mem_req_m,
  input  logic                mem_ack_m,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_m,
  output logic                flush_w,
  output logic                mc_busy,
  output logic [31:0]         stall_cycles,
  output logic                mc_state_o,
  output logic                mem_state_o,
  output logic [CW-1:0]       mc_cnt_o
);

  typedef enum logic { MC_IDLE = 1'b0, MC_BUSY = 1'b1 } mc_state_t;
  typedef enum logic { M_IDLE  = 1'b0, M_WAIT  = 1'b1 } mem_state_t;

  // Counter load value: stall cycles still owed after the start cycle.
  localparam logic [CW-1:0] CNT_INIT = (MC_LATENCY > 1) ? CW'(MC_LATENCY - 2) : '0;
  localparam logic          MC_ON    = (MC_LATENCY > 1);

  mc_state_t     mc_state_q;
  mem_state_t    mem_state_q;
  logic [CW-1:0] mc_cnt_q;
  logic [31:0]   stall_cnt_q;

  logic          mem_stall;
  logic          mc_stall;
  logic          lw_stall;
  logic          any_stall;
  logic          ex_stall;

  // A register index may be matched only if it is not the hardwired zero.
  function automatic logic real_reg(input logic [REG_BITS-1:0] r);
    return !((ZERO_REG != 0) && (r == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs,
                                         input logic                 wr_m,
                                         input logic [REG_BITS-1:0] dst_m,
                                         input logic                 wr_w,
                                         input logic [REG_BITS-1:0] dst_w);
    logic [1:0] sel;
    sel = 2'b00;
    // MEM holds the younger value, so it wins over WB.
    if (wr_m && (dst_m == rs) && real_reg(dst_m)) begin
      sel = 2'b10;
    end else if (wr_w && (dst_w == rs) && real_reg(dst_w)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
    fwd_b_e = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
  end

  // --------------------------------------------------------------------------
  // Stall sources
  // --------------------------------------------------------------------------
  always_comb begin
    mem_stall = mem_req_m && !mem_ack_m;

    lw_stall  = memtoreg_e && real_reg(rd_e) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d));

    mc_stall  = 1'b0;
    if (mc_state_q == MC_IDLE) begin
      mc_stall = mc_start_e && MC_ON;
    end else begin
      mc_stall = (mc_cnt_q != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Multi-cycle FSM. The counter only advances when EX is not frozen by a
  // memory wait. When the count has run out but a memory wait is freezing
  // the pipe, the op is still sitting in EX, so the FSM stays in MC_BUSY
  // until the op can actually leave; dropping to MC_IDLE early would see
  // the same op's mc_start_e again and restart it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_state_q <= MC_IDLE;
      mc_cnt_q   <= '0;
    end else begin
      case (mc_state_q)
        MC_IDLE: begin
          if (mc_start_e && MC_ON && !mem_stall) begin
            mc_state_q <= MC_BUSY;
            mc_cnt_q   <= CNT_INIT;
          end
        end
        MC_BUSY: begin
          if (mc_cnt_q != '0) begin
            if (!mem_stall) begin
              mc_cnt_q <= mc_cnt_q - 1'b1;
            end
          end else if (!mem_stall) begin
            mc_state_q <= MC_IDLE;
          end
        end
        default: begin
          mc_state_q <= MC_IDLE;
          mc_cnt_q   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory wait FSM (tracks whether the MEM access is outstanding).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state_q <= M_IDLE;
    end else begin
      case (mem_state_q)
        M_IDLE:  if (mem_stall) mem_state_q <= M_WAIT;
        M_WAIT:  if (mem_ack_m) mem_state_q <= M_IDLE;
        default: mem_state_q <= M_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output equations. Reset gates all stall/flush controls so they drop the
  // moment reset rises, independent of the input pins.
  // --------------------------------------------------------------------------
  always_comb begin
    any_stall = !reset && (mem_stall || mc_stall || lw_stall);
    ex_stall  = !reset && (mem_stall || mc_stall);

    stall_f = any_stall;
    stall_d = any_stall;
    stall_e = ex_stall;
    stall_m = !reset && mem_stall;

    flush_w = !reset && mem_stall;
    flush_m = !reset && mc_stall && !mem_stall;
    // A branch held in a frozen EX flushes on its first unstalled cycle.
    flush_e = !reset && (lw_stall || pc_src_e) && !ex_stall;
    flush_d = !reset && pc_src_e && !ex_stall;
  end

  // --------------------------------------------------------------------------
  // Stall statistics (wraps naturally at 2^32).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (any_stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mc_busy      = (mc_state_q == MC_BUSY);
  assign mc_state_o   = mc_state_q;
  assign mem_state_o  = mem_state_q;
  assign mc_cnt_o     = mc_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed scenarios followed by randomized cycles. Every cycle all DUT
//   outputs are compared against a reference model that tracks a
//   multi-cycle op by how many EX cycles it has completed, rather than by
//   a state/counter pair.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int RB  = 4;
  localparam int LAT = 4;
  localparam int CW  = (LAT > 2) ? $clog2(LAT - 1) : 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [RB-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic regwrite_m, regwrite_w, memtoreg_e, mc_start_e, pc_src_e;
  logic mem_req_m, mem_ack_m;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic mc_busy;
  logic [31:0] stall_cycles;
  logic mc_state_o, mem_state_o;
  logic [CW-1:0] mc_cnt_o;

  hazard_unit #(.REG_BITS(RB), .MC_LATENCY(LAT), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ack_m(mem_ack_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles),
    .mc_state_o(mc_state_o), .mem_state_o(mem_state_o), .mc_cnt_o(mc_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_on;       // a multi-cycle op occupies EX
  int          m_done;     // EX cycles the op has completed so far
  bit          m_wait;     // memory access outstanding
  logic [31:0] m_stalls;   // cycles with stall_f seen

  // observation counters for directed scenarios
  int obs_stall_e, obs_busy, obs_flush_d, obs_stall_f;

  function automatic logic [1:0] ref_fwd(input logic [RB-1:0] rs);
    if (regwrite_m && rd_m == rs && rd_m != 0) return 2'b10;
    if (regwrite_w && rd_w == rs && rd_w != 0) return 2'b01;
    return 2'b00;
  endfunction

  // Evaluate one cycle: inputs already driven, checks run #1 later, then
  // the model advances across the coming rising edge.
  task automatic tick(input string tag);
    bit mem_s, lw_s, mc_s, any_s, ex_s;
    logic [3:0] e_stall, e_flush;
    #1;
    mem_s = mem_req_m && !mem_ack_m;
    lw_s  = memtoreg_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (m_on) mc_s = (m_done < LAT - 1);
    else      mc_s = mc_start_e && (LAT > 1);
    if (reset) begin
      mem_s = 0; lw_s = 0; mc_s = 0;
      m_on = 0; m_done = 0; m_wait = 0; m_stalls = 0;
    end
    any_s = mem_s | mc_s | lw_s;
    ex_s  = mem_s | mc_s;
    e_stall = {any_s, any_s, ex_s, mem_s};
    e_flush = {pc_src_e & !ex_s & !reset, (lw_s | pc_src_e) & !ex_s & !reset,
               mc_s & !mem_s, mem_s};

    exp_q.push_back({30'd0, ref_fwd(rs1_e)});
    exp_q.push_back({30'd0, ref_fwd(rs2_e)});
    exp_q.push_back({28'd0, e_stall});
    exp_q.push_back({28'd0, e_flush});
    exp_q.push_back({31'd0, m_on});
    exp_q.push_back(m_stalls);
    exp_q.push_back({31'd0, m_wait});
    check({tag, ".fwd_a"},  {30'd0, fwd_a_e}, exp_q.pop_front());
    check({tag, ".fwd_b"},  {30'd0, fwd_b_e}, exp_q.pop_front());
    check({tag, ".stall"},  {28'd0, stall_f, stall_d, stall_e, stall_m}, exp_q.pop_front());
    check({tag, ".flush"},  {28'd0, flush_d, flush_e, flush_m, flush_w}, exp_q.pop_front());
    check({tag, ".busy"},   {31'd0, mc_busy}, exp_q.pop_front());
    check({tag, ".scount"}, stall_cycles, exp_q.pop_front());
    check({tag, ".memst"},  {31'd0, mem_state_o}, exp_q.pop_front());

    obs_stall_e += int'(stall_e);
    obs_busy    += int'(mc_busy);
    obs_flush_d += int'(flush_d);
    obs_stall_f += int'(stall_f);

    // advance model across the rising edge
    if (!reset) begin
      if (any_s) m_stalls = m_stalls + 32'd1;
      if (m_on) begin
        if (!mem_s) begin
          if (m_done >= LAT - 1) m_on = 0;
          else m_done++;
        end
      end else if (mc_start_e && LAT > 1 && !mem_s) begin
        m_on = 1;
        m_done = 1;
      end
      if (!m_wait && mem_s) m_wait = 1;
      else if (m_wait && mem_ack_m) m_wait = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0; mc_start_e = 0;
    pc_src_e = 0; mem_req_m = 0; mem_ack_m = 0;
  endtask

  task automatic clear_obs();
    obs_stall_e = 0; obs_busy = 0; obs_flush_d = 0; obs_stall_f = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_on = 0; m_done = 0; m_wait = 0; m_stalls = 0;
    clear_obs();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    tick("reset");
    reset = 1'b0;
    tick("idle");

    // forwarding priority and zero register
    rd_m = 5; rd_w = 5; rs1_e = 5; rs2_e = 5; regwrite_m = 1; regwrite_w = 1;
    tick("fwd_mem");
    check("fwd_mem_const", {30'd0, fwd_a_e}, 32'd2);
    regwrite_m = 0;
    tick("fwd_wb");
    check("fwd_wb_const", {30'd0, fwd_a_e}, 32'd1);
    regwrite_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
    tick("fwd_zero");
    check("fwd_zero_const", {30'd0, fwd_a_e}, 32'd0);
    idle_inputs();

    // load-use
    memtoreg_e = 1; rd_e = 3; rs2_d = 3;
    tick("loaduse");
    idle_inputs();
    tick("loaduse_after");
    check("loaduse_count", stall_cycles, 32'd1);

    // multi-cycle op held 4 cycles
    clear_obs();
    mc_start_e = 1;
    for (int i = 0; i < 4; i++) tick("mc");
    mc_start_e = 0;
    tick("mc_after");
    check("mc_stall_len", obs_stall_e, 32'd3);
    check("mc_busy_len", obs_busy, 32'd3);

    // memory wait of 2 cycles, then same-cycle ack
    clear_obs();
    mem_req_m = 1; mem_ack_m = 0;
    tick("mem_w1");
    tick("mem_w2");
    mem_ack_m = 1;
    tick("mem_ack");
    tick("mem_fast");
    idle_inputs();
    tick("mem_after");
    check("mem_stall_len", obs_stall_f, 32'd2);

    // overlap: MC op with a 2-cycle memory wait at cnt=1, branch held in EX
    clear_obs();
    mc_start_e = 1; pc_src_e = 1;
    tick("ovl1");
    tick("ovl2");
    mem_req_m = 1; mem_ack_m = 0;
    tick("ovl3");
    tick("ovl4");
    mem_ack_m = 1;
    tick("ovl5");
    mem_req_m = 0; mem_ack_m = 0;
    check("ovl_no_early_flush", obs_flush_d, 32'd0);
    tick("ovl6");
    idle_inputs();
    tick("ovl7");
    check("ovl_ex_stall_len", obs_stall_e, 32'd5);
    check("ovl_flush_once", obs_flush_d, 32'd1);

    // reset in the middle of a busy op
    mc_start_e = 1;
    tick("rst_mc1");
    tick("rst_mc2");
    reset = 1;
    tick("rst_hit");
    check("rst_busy_drop", {31'd0, mc_busy}, 32'd0);
    check("rst_count_zero", stall_cycles, 32'd0);
    reset = 0;
    clear_obs();
    for (int i = 0; i < 4; i++) tick("rst_new");
    mc_start_e = 0;
    tick("rst_new_after");
    check("rst_new_len", obs_stall_e, 32'd3);

    // randomized cycles
    for (int i = 0; i < 600; i++) begin
      rs1_d = RB'($urandom_range(0, 3)); rs2_d = RB'($urandom_range(0, 3));
      rs1_e = RB'($urandom_range(0, 3)); rs2_e = RB'($urandom_range(0, 3));
      rd_e  = RB'($urandom_range(0, 3)); rd_m  = RB'($urandom_range(0, 3));
      rd_w  = RB'($urandom_range(0, 3));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      memtoreg_e = ($urandom_range(0, 3) == 0);
      mc_start_e = ($urandom_range(0, 2) == 0);
      pc_src_e   = ($urandom_range(0, 4) == 0);
      mem_req_m  = ($urandom_range(0, 2) == 0);
      mem_ack_m  = ($urandom_range(0, 1) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick("rand");
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
